int_controller: RTL
===================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-003 SHALL have port interrupt_signal, input, 1, asynchronous external interrupt, serviced on its rising edge.
REQ-004 SHALL have port pc_current, input, 32, PC of the next unexecuted instruction (fetch pc_plus_one).
REQ-005 SHALL have port flags, input, 3, current flag register {C,N,Z}.
REQ-006 SHALL have port branch_pending, input, 1, control transfer in flight in decode/execute; entry deferred while high.
REQ-007 SHALL have port rti_done, input, 1, one-cycle pulse when RTI retires in memory stage.
REQ-008 SHALL have port vector_data, input, 16, memory read data, valid one cycle after vector_read.
REQ-009 SHALL have port stall_fetch, output, 1, freeze PC and fetch register.
REQ-010 SHALL have port flush_decode, output, 1, convert the decode-stage instruction to NOP.
REQ-011 SHALL have ports push_valid (output, 1) and push_data (output, 16), a stack-push request to memory stage.
REQ-012 SHALL have ports vector_read (output, 1) and vector_addr (output, 16), vector fetch request.
REQ-013 SHALL have ports pc_load (output, 1) and pc_load_value (output, 32), a PC overwrite to fetch.
REQ-014 SHALL have ports int_ack (output, 1), one-cycle entry pulse, and int_busy (output, 1), high while state != IDLE.

Function
REQ-015 SHALL pass interrupt_signal through two synchronizer flops plus a third flop; rising edge = sync2 & ~sync3.
REQ-016 SHALL set a one-deep pending bit on a detected edge; extra edges while pending SHALL collapse into it.
REQ-017 SHALL implement states IDLE, FLUSH, PUSH_PCH, PUSH_PCL, PUSH_FLG, VEC_LO, VEC_HI, LOAD, IN_ISR.
REQ-018 IDLE->FLUSH when (edge or pending) and branch_pending=0; otherwise stay in IDLE with pending held.
REQ-019 FLUSH: SHALL assert int_ack, flush_decode, stall_fetch; capture pc_current into saved_pc; clear pending.
REQ-020 PUSH_PCH then PUSH_PCL: SHALL assert push_valid with push_data = saved_pc[31:16], then saved_pc[15:0].
REQ-021 PUSH_FLG: SHALL assert push_valid with push_data = {13'b0, flags}.
REQ-022 VEC_LO: vector_read=1, vector_addr=0; VEC_HI: vector_read=1, vector_addr=1, capture vector_data as vec_hi.
REQ-023 LOAD: SHALL assert pc_load=1 with pc_load_value = {vec_hi, vector_data}, then go to IN_ISR.
REQ-024 stall_fetch SHALL be high in every state from FLUSH through LOAD inclusive, low otherwise.
REQ-025 IN_ISR: SHALL wait for rti_done, then return to IDLE; rti_done in any other state SHALL be ignored.
REQ-026 An edge arriving in any non-IDLE state SHALL set pending; it SHALL be serviced from IDLE after return (no nesting).
REQ-027 All single-cycle strobes SHALL be registered state decodes and SHALL be zero in IDLE and IN_ISR.

Reset
REQ-028 rst=0 at a clock edge SHALL force state IDLE; clear pending, sync flops, saved_pc, and vec_hi; drive all outputs 0, including mid-sequence.
REQ-029 The first edge detection after reset release SHALL require a fresh 0->1 transition at sync2.

Configuration
REQ-030 Macro INT_FLAGS_SAVE_EN defined: PUSH_PCL->PUSH_FLG->VEC_LO, three pushes, seven-cycle stall.
REQ-031 Macro INT_FLAGS_SAVE_EN undefined: PUSH_FLG SHALL be absent, PUSH_PCL->VEC_LO, two pushes, six-cycle stall.

Verification
REQ-032 Basic entry: interrupt_signal rises before edge 0, pc_current=0x00000123, flags=3'b101, mem[0]=0x0000, mem[1]=0x0200. Response: int_ack in cycle after edge 2; pushes 0x0000, 0x0123, 0x0005; pc_load=1 with 0x00000200; stall_fetch high seven cycles.
REQ-033 Deferral: branch_pending=1 for 4 cycles across the detected edge. Response: FLUSH occurs only in the cycle after branch_pending falls, with no lost interrupt.
REQ-034 Nested edge: second rising edge during PUSH_PCL. Response: no re-entry until rti_done; after rti_done, IDLE for one cycle, then FLUSH.
REQ-035 Collapse: three edges while IN_ISR. Response: exactly one further entry after rti_done.
REQ-036 Reset mid-sequence: rst=0 during VEC_LO. Response: all outputs 0 on the next cycle, pending cleared, no pc_load.
REQ-037 Build without INT_FLAGS_SAVE_EN and rerun REQ-032. Response: only 0x0000 and 0x0123 pushed; six-cycle stall.

Source files
------------

// File: rtl/int_controller.sv
// Interrupt entry sequencer: synchronizes an external interrupt, flushes decode, pushes context,
// fetches the two-word vector and loads the PC. Define INT_FLAGS_SAVE_EN to also push the flags.
module int_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_signal,
  input  logic [31:0] pc_current,
  input  logic [2:0]  flags,
  input  logic        branch_pending,
  input  logic        rti_done,
  input  logic [15:0] vector_data,
  output logic        stall_fetch,
  output logic        flush_decode,
  output logic        push_valid,
  output logic [15:0] push_data,
  output logic        vector_read,
  output logic [15:0] vector_addr,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        int_ack,
  output logic        int_busy
);

  typedef enum logic [3:0] {
    StIdle,
    StFlush,
    StPushPch,
    StPushPcl,
`ifdef INT_FLAGS_SAVE_EN
    StPushFlg,
`endif
    StVecLo,
    StVecHi,
    StLoad,
    StInIsr
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        pending_q, pending_d;
  logic [31:0] saved_pc_q;
  logic [15:0] vec_hi_q;
  logic        edge_det;

  assign edge_det = sync2_q & ~sync3_q;

`ifndef INT_FLAGS_SAVE_EN
  logic unused_flags;
  assign unused_flags = ^flags;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      pending_q  <= 1'b0;
      saved_pc_q <= 32'h0;
      vec_hi_q   <= 16'h0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= interrupt_signal;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      pending_q <= pending_d;
      if (state_q == StFlush) saved_pc_q <= pc_current;
      if (state_q == StVecHi) vec_hi_q <= vector_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (edge_det) pending_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if ((edge_det || pending_q) && !branch_pending) state_d = StFlush;
      end
      StFlush: begin
        // Entry consumes the pending request; only an edge seen this cycle survives.
        pending_d = edge_det;
        state_d   = StPushPch;
      end
      StPushPch: state_d = StPushPcl;
`ifdef INT_FLAGS_SAVE_EN
      StPushPcl: state_d = StPushFlg;
      StPushFlg: state_d = StVecLo;
`else
      StPushPcl: state_d = StVecLo;
`endif
      StVecLo: state_d = StVecHi;
      StVecHi: state_d = StLoad;
      StLoad:  state_d = StInIsr;
      StInIsr: begin
        if (rti_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_fetch   = 1'b0;
    flush_decode  = 1'b0;
    push_valid    = 1'b0;
    push_data     = 16'h0;
    vector_read   = 1'b0;
    vector_addr   = 16'h0;
    pc_load       = 1'b0;
    pc_load_value = 32'h0;
    int_ack       = 1'b0;
    int_busy      = (state_q != StIdle);
    unique case (state_q)
      StFlush: begin
        stall_fetch  = 1'b1;
        flush_decode = 1'b1;
        int_ack      = 1'b1;
      end
      StPushPch: begin
        stall_fetch = 1'b1;
        push_valid  = 1'b1;
        push_data   = saved_pc_q[31:16];
      end
      StPushPcl: begin
        stall_fetch = 1'b1;
        push_valid  = 1'b1;
        push_data   = saved_pc_q[15:0];
      end
`ifdef INT_FLAGS_SAVE_EN
      StPushFlg: begin
        stall_fetch = 1'b1;
        push_valid  = 1'b1;
        push_data   = {13'b0, flags};
      end
`endif
      StVecLo: begin
        stall_fetch = 1'b1;
        vector_read = 1'b1;
      end
      StVecHi: begin
        stall_fetch = 1'b1;
        vector_read = 1'b1;
        vector_addr = 16'd1;
      end
      StLoad: begin
        stall_fetch   = 1'b1;
        pc_load       = 1'b1;
        pc_load_value = {vec_hi_q, vector_data};
      end
      default: ;
    endcase
  end

endmodule
